// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial WIDTH-bit adder built around a single shared
// full-adder cell, one bit per clock, with a start/busy/done handshake.
// Optional feature: define SERIAL_ADD_OVF_EN to add the signed 'overflow'
// output, registered alongside sum.
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             overflow
`endif
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] rs;
    logic             cy;
    logic [CW-1:0]    cnt;
    logic             fa_sum;
    logic             fa_cout;
    logic             accept;
    logic             last;

    // Shared 1-bit full adder fed from the operand LSBs and the carry flop
    always_comb begin
        fa_sum  = sa[0] ^ sb[0] ^ cy;
        fa_cout = (sa[0] & sb[0]) | (cy & (sa[0] ^ sb[0]));
    end

    // Next-state decode; start only matters in IDLE and DONE
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (cnt == CW'(WIDTH - 1)) begin
                    last      = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = S_RUN;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand/result shift registers, carry flop and bit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa  <= '0;
            sb  <= '0;
            rs  <= '0;
            cy  <= 1'b0;
            cnt <= '0;
        end else if (accept) begin
            sa  <= a;
            sb  <= b;
            rs  <= '0;
            cy  <= carry_in;
            cnt <= '0;
        end else if (state == S_RUN) begin
            sa <= sa >> 1;
            sb <= sb >> 1;
            rs <= {fa_sum, rs[WIDTH-1:1]};
            cy <= fa_cout;
            // Counter saturates at the last bit so it never wraps
            if (!last) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // Handshake flags follow the next state so they are clean flop outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_nxt == S_RUN);
            done <= (state_nxt == S_DONE);
        end
    end

    // Result registers update only when the final bit is produced
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum       <= '0;
            carry_out <= 1'b0;
        end else if (last) begin
            sum       <= {fa_sum, rs[WIDTH-1:1]};
            carry_out <= fa_cout;
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    // Signed overflow: carry into the MSB (cy during the last bit) vs carry out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (last) begin
            overflow <= cy ^ fa_cout;
        end
    end
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed plus randomized checks of serial_add_ctrl
// against an arithmetic reference model (a + b + carry_in).
module tb_serial_add_ctrl;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
`ifdef SERIAL_ADD_OVF_EN
    logic             overflow;
    logic             exp_ovf;
`endif

    int               nvec;
    int               nerr;
    logic [WIDTH-1:0] exp_sum;
    logic             exp_co;
    bit               b2b;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .carry_out (carry_out)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .overflow  (overflow)
`endif
    );

    // Free-running clock, 10 time-unit period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nvec++;
        assert (obs === expv)
        else begin
            nerr++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Expects to be entered just after a negedge with start=1 and operands driven.
    // Returns at the negedge of the done cycle with start dropped.
    task automatic run_op(input bit noisy);
        logic [WIDTH:0] full;
`ifdef SERIAL_ADD_OVF_EN
        int             ssum;
`endif
        full = (WIDTH+1)'(a) + (WIDTH+1)'(b) + (WIDTH+1)'(carry_in);
`ifdef SERIAL_ADD_OVF_EN
        ssum = int'($signed(a)) + int'($signed(b)) + int'(carry_in);
`endif
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c <= int'(WIDTH); c++) begin
            @(negedge clk);
            chk("run_busy", 32'(busy), 32'(1'b1));
            chk("run_done", 32'(done), 32'(1'b0));
            chk("run_sum_hold", 32'(sum), 32'(exp_sum));
            chk("run_co_hold", 32'(carry_out), 32'(exp_co));
`ifdef SERIAL_ADD_OVF_EN
            chk("run_ovf_hold", 32'(overflow), 32'(exp_ovf));
`endif
            if (noisy) begin
                start    = 1'($urandom_range(0, 1));
                a        = WIDTH'($urandom);
                b        = WIDTH'($urandom);
                carry_in = 1'($urandom_range(0, 1));
            end
        end
        @(negedge clk);
        start   = 1'b0;
        exp_sum = full[WIDTH-1:0];
        exp_co  = full[WIDTH];
`ifdef SERIAL_ADD_OVF_EN
        exp_ovf = (ssum > 127) || (ssum < -128);
        chk("done_ovf", 32'(overflow), 32'(exp_ovf));
`endif
        chk("done_pulse", 32'(done), 32'(1'b1));
        chk("done_busy", 32'(busy), 32'(1'b0));
        chk("done_sum", 32'(sum), 32'(exp_sum));
        chk("done_co", 32'(carry_out), 32'(exp_co));
    endtask

    task automatic drive(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb, input logic vc);
        start    = 1'b1;
        a        = va;
        b        = vb;
        carry_in = vc;
    endtask

    task automatic idle_chk();
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'(1'b0));
        chk("idle_done", 32'(done), 32'(1'b0));
        chk("idle_sum", 32'(sum), 32'(exp_sum));
    endtask

    // Directed test-plan steps followed by randomized operations
    initial begin
        nvec     = 0;
        nerr     = 0;
        exp_sum  = '0;
        exp_co   = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
        exp_ovf  = 1'b0;
`endif
        rst_n    = 1'b0;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        carry_in = 1'b0;
        b2b      = 1'b0;

        #12;
        chk("rst_busy", 32'(busy), 32'(1'b0));
        chk("rst_done", 32'(done), 32'(1'b0));
        chk("rst_sum", 32'(sum), 32'(0));
        chk("rst_co", 32'(carry_out), 32'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;

        // Basic add
        @(negedge clk);
        drive(8'h5A, 8'h33, 1'b0);
        run_op(1'b0);
        chk("basic_sum", 32'(sum), 32'h8D);
        chk("basic_co", 32'(carry_out), 32'(1'b0));
        idle_chk();

        // Full carry ripple
        @(negedge clk);
        drive(8'hFF, 8'h01, 1'b0);
        run_op(1'b0);
        chk("ripple1_sum", 32'(sum), 32'h00);
        chk("ripple1_co", 32'(carry_out), 32'(1'b1));
        @(negedge clk);
        drive(8'hFF, 8'hFF, 1'b1);
        run_op(1'b0);
        chk("ripple2_sum", 32'(sum), 32'hFF);
        chk("ripple2_co", 32'(carry_out), 32'(1'b1));

        // Start during RUN is ignored
        @(negedge clk);
        drive(8'h10, 8'h20, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        drive(8'hAA, 8'h55, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (WIDTH - 3) @(posedge clk);
        @(negedge clk);
        chk("prot_done", 32'(done), 32'(1'b1));
        chk("prot_sum", 32'(sum), 32'h30);
        chk("prot_co", 32'(carry_out), 32'(1'b0));
        exp_sum = 8'h30;
        exp_co  = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
        exp_ovf = 1'b0;
`endif
        idle_chk();
        idle_chk();

        // Back-to-back with start held high
        @(negedge clk);
        drive(8'h01, 8'h02, 1'b0);
        run_op(1'b0);
        chk("b2b1_sum", 32'(sum), 32'h03);
        chk("b2b1_co", 32'(carry_out), 32'(1'b0));
        drive(8'h80, 8'h80, 1'b0);
        run_op(1'b0);
        chk("b2b2_sum", 32'(sum), 32'h00);
        chk("b2b2_co", 32'(carry_out), 32'(1'b1));
        idle_chk();

        // Asynchronous reset during RUN cycle 4
        @(negedge clk);
        drive(8'h77, 8'h66, 1'b1);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'(1'b0));
        chk("mid_rst_done", 32'(done), 32'(1'b0));
        chk("mid_rst_sum", 32'(sum), 32'(0));
        chk("mid_rst_co", 32'(carry_out), 32'(1'b0));
        exp_sum = '0;
        exp_co  = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
        exp_ovf = 1'b0;
`endif
        @(negedge clk);
        rst_n = 1'b1;
        idle_chk();
        @(negedge clk);
        drive(8'h0F, 8'h01, 1'b0);
        run_op(1'b0);
        chk("post_rst_sum", 32'(sum), 32'h10);
        idle_chk();

`ifdef SERIAL_ADD_OVF_EN
        // Signed overflow cases
        @(negedge clk);
        drive(8'h7F, 8'h01, 1'b0);
        run_op(1'b0);
        chk("ovf1_sum", 32'(sum), 32'h80);
        chk("ovf1_flag", 32'(overflow), 32'(1'b1));
        chk("ovf1_co", 32'(carry_out), 32'(1'b0));
        @(negedge clk);
        drive(8'hFF, 8'h01, 1'b0);
        run_op(1'b0);
        chk("ovf2_flag", 32'(overflow), 32'(1'b0));
`endif

        // Randomized operations, random noise during RUN, random back-to-back
        b2b = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (!b2b) begin
                @(negedge clk);
            end
            drive(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)));
            run_op(1'($urandom_range(0, 1)));
            b2b = 1'($urandom_range(0, 1));
        end
        idle_chk();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
